// File: rtl/n64adv2_vout_stage_pkg.sv
// Shared definitions for the HDMI video output stage: FSM state encoding,
// legal parameter ranges and a range-check helper used at elaboration.
package n64adv2_vout_stage_pkg;

    typedef enum logic [1:0] {
        ST_MUTE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RUN  = 2'b10
    } vout_state_e;

    localparam int PIPE_DEPTH_MIN  = 1;
    localparam int PIPE_DEPTH_MAX  = 4;
    localparam int MUTE_FRAMES_MIN = 1;
    localparam int MUTE_FRAMES_MAX = 15;

    localparam int FRAME_CNT_W = 4;

    function automatic logic in_range(input int val, input int lo, input int hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/n64adv2_vout_stage_delay_line.sv
// Register chain of configurable width and depth with asynchronous
// active-low clear. A depth of zero collapses to a plain wire.
module n64adv2_vout_stage_delay_line #(
    parameter int width = 1,
    parameter int depth = 1
) (
    input  logic             VCLK,
    input  logic             nVRST,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    generate
        if (depth == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = VCLK ^ nVRST;
            assign dout = din;
        end else begin : g_regs
            logic [width-1:0] stage_r [depth];

            // shift the bus one stage per clock, clearing every stage on reset
            always_ff @(posedge VCLK or negedge nVRST) begin
                if (!nVRST) begin
                    for (int i = 0; i < depth; i++) begin
                        stage_r[i] <= '0;
                    end
                end else begin
                    stage_r[0] <= din;
                    for (int i = 1; i < depth; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[depth-1];
        end
    endgenerate

endmodule

// File: rtl/n64adv2_vout_stage.sv
// Video output stage between the scaler and the ADV7513 pins.
// Pipelines syncs/DE/data by pipe_depth clocks, applies per-sync output
// polarity, forces blanking to zero and hides pixels behind a frame-aligned
// mute/unmute sequence. The last pipeline stage is the pin register.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_MUTE | mute requested; frame counter held at 0, pixels tagged muted
//   ST_WAIT | mute released; counting VSYNC_i rises up to mute_frames
//   ST_RUN  | live video passes through untouched
module n64adv2_vout_stage
    import n64adv2_vout_stage_pkg::*;
#(
    parameter int                         color_width_o = 8,
    parameter int                         pipe_depth    = 2,
    parameter int                         mute_frames   = 2,
    parameter logic [3*color_width_o-1:0] mute_color    = '0,
    parameter bit                         blank_zero    = 1'b1
) (
    input  logic                         VCLK_Tx,
    input  logic                         nVRST_Tx,
    input  logic                         mute_req_i,
    input  logic                         vs_pol_i,
    input  logic                         hs_pol_i,
    input  logic                         VSYNC_i,
    input  logic                         HSYNC_i,
    input  logic                         DE_i,
    input  logic [3*color_width_o-1:0]   VD_i,
    output logic                         VSYNC_o,
    output logic                         HSYNC_o,
    output logic                         DE_o,
    output logic [3*color_width_o-1:0]   VD_o,
    output logic                         muted_o
);

    localparam int vd_w   = 3 * color_width_o;
    localparam int pipe_w = vd_w + 4;
    localparam logic [FRAME_CNT_W-1:0] frames_target = FRAME_CNT_W'(mute_frames);

    generate
        if (!in_range(pipe_depth, PIPE_DEPTH_MIN, PIPE_DEPTH_MAX)) begin : g_bad_pipe_depth
            $error("n64adv2_vout_stage: pipe_depth must be within 1..4");
        end
        if (!in_range(mute_frames, MUTE_FRAMES_MIN, MUTE_FRAMES_MAX)) begin : g_bad_mute_frames
            $error("n64adv2_vout_stage: mute_frames must be within 1..15");
        end
    endgenerate

    vout_state_e            state_r, state_nx;
    logic [FRAME_CNT_W-1:0] frame_cnt_r, frame_cnt_nx;
    logic                   vs_prev_r;
    logic                   vs_rise;

    // Edge detect on the raw input so the polarity setting cannot fake a rise.
    assign vs_rise = VSYNC_i & ~vs_prev_r;

    // FSM state, frame counter, VSYNC history and the registered mute status
    always_ff @(posedge VCLK_Tx or negedge nVRST_Tx) begin
        if (!nVRST_Tx) begin
            state_r     <= ST_MUTE;
            frame_cnt_r <= '0;
            vs_prev_r   <= 1'b0;
            muted_o     <= 1'b1;
        end else begin
            state_r     <= state_nx;
            frame_cnt_r <= frame_cnt_nx;
            vs_prev_r   <= VSYNC_i;
            muted_o     <= (state_r != ST_RUN);
        end
    end

    // Next-state logic; a mute request always beats a coincident VSYNC rise.
    always_comb begin
        state_nx     = state_r;
        frame_cnt_nx = frame_cnt_r;
        unique case (state_r)
            ST_MUTE: begin
                frame_cnt_nx = '0;
                if (!mute_req_i) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mute_req_i) begin
                    state_nx     = ST_MUTE;
                    frame_cnt_nx = '0;
                end else if (vs_rise) begin
                    if (frame_cnt_r != '1) begin
                        frame_cnt_nx = frame_cnt_r + 1'b1;
                    end
                    if (frame_cnt_r + 1'b1 == frames_target) begin
                        state_nx = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (mute_req_i) begin
                    state_nx     = ST_MUTE;
                    frame_cnt_nx = '0;
                end
            end
            default: begin
                state_nx     = ST_MUTE;
                frame_cnt_nx = '0;
            end
        endcase
    end

    // Stage 0: the mute tag is taken from the next state so that the pixel
    // sampled together with the deciding event already carries the new status.
    logic [pipe_w-1:0] s0_bus;
    logic [pipe_w-1:0] dl_bus;

    assign s0_bus = {(state_nx != ST_RUN),
                     VSYNC_i ^ vs_pol_i,
                     HSYNC_i ^ hs_pol_i,
                     DE_i,
                     VD_i};

    n64adv2_vout_stage_delay_line #(
        .width (pipe_w),
        .depth (pipe_depth - 1)
    ) u_delay_line (
        .VCLK  (VCLK_Tx),
        .nVRST (nVRST_Tx),
        .din   (s0_bus),
        .dout  (dl_bus)
    );

    logic            dl_tag, dl_vs, dl_hs, dl_de;
    logic [vd_w-1:0] dl_vd;
    logic [vd_w-1:0] vd_sel;

    assign dl_tag = dl_bus[vd_w+3];
    assign dl_vs  = dl_bus[vd_w+2];
    assign dl_hs  = dl_bus[vd_w+1];
    assign dl_de  = dl_bus[vd_w];
    assign dl_vd  = dl_bus[vd_w-1:0];

    // Pixel data source: blanking level first, then mute colour, else video.
    always_comb begin
        vd_sel = dl_vd;
        if (blank_zero && !dl_de) begin
            vd_sel = '0;
        end else if (dl_tag) begin
            vd_sel = mute_color;
        end
    end

    // Output (pin) register; syncs and DE pass regardless of mute to keep the link up.
    always_ff @(posedge VCLK_Tx or negedge nVRST_Tx) begin
        if (!nVRST_Tx) begin
            VSYNC_o <= 1'b0;
            HSYNC_o <= 1'b0;
            DE_o    <= 1'b0;
            VD_o    <= '0;
        end else begin
            VSYNC_o <= dl_vs;
            HSYNC_o <= dl_hs;
            DE_o    <= dl_de;
            VD_o    <= vd_sel;
        end
    end

endmodule

// File: tb/tb_n64adv2_vout_stage.sv
// Directed bench for the video output stage. Four instances (pipe_depth 1..4)
// share the same stimulus; every driven pixel is recorded together with its
// hand-assigned mute tag, and each output is compared to the pixel recorded
// pipe_depth clocks earlier. Frames use a compact 12x4 timing.
module tb_n64adv2_vout_stage;

    localparam logic [23:0] MUTE_C = 24'h102030;

    logic        VCLK_Tx    = 1'b0;
    logic        nVRST_Tx   = 1'b1;
    logic        mute_req_i = 1'b0;
    logic        vs_pol_i   = 1'b0;
    logic        hs_pol_i   = 1'b0;
    logic        VSYNC_i    = 1'b0;
    logic        HSYNC_i    = 1'b0;
    logic        DE_i       = 1'b0;
    logic [23:0] VD_i       = '0;

    logic        vs_o    [4];
    logic        hs_o    [4];
    logic        de_o    [4];
    logic        muted_o [4];
    logic [23:0] vd_o    [4];

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic        tag;
        logic [23:0] vd;
    } hist_t;

    hist_t       hist [5];
    logic [23:0] ramp = 24'h000001;

    always #5 VCLK_Tx = ~VCLK_Tx;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        n64adv2_vout_stage #(
            .color_width_o (8),
            .pipe_depth    (g + 1),
            .mute_frames   (2),
            .mute_color    (MUTE_C),
            .blank_zero    (1'b1)
        ) u_dut (
            .VCLK_Tx    (VCLK_Tx),
            .nVRST_Tx   (nVRST_Tx),
            .mute_req_i (mute_req_i),
            .vs_pol_i   (vs_pol_i),
            .hs_pol_i   (hs_pol_i),
            .VSYNC_i    (VSYNC_i),
            .HSYNC_i    (HSYNC_i),
            .DE_i       (DE_i),
            .VD_i       (VD_i),
            .VSYNC_o    (vs_o[g]),
            .HSYNC_o    (hs_o[g]),
            .DE_o       (de_o[g]),
            .VD_o       (vd_o[g]),
            .muted_o    (muted_o[g])
        );
    end

    task automatic check(input string name, input int d, input logic [23:0] obs, input logic [23:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s depth=%0d observed=%h expected=%h", name, d, obs, exp);
        end
    endtask

    task automatic check_reset();
        for (int g = 0; g < 4; g++) begin
            check("rst_VSYNC_o", g + 1, {23'b0, vs_o[g]}, 24'h0);
            check("rst_HSYNC_o", g + 1, {23'b0, hs_o[g]}, 24'h0);
            check("rst_DE_o",    g + 1, {23'b0, de_o[g]}, 24'h0);
            check("rst_VD_o",    g + 1, vd_o[g],          24'h0);
            check("rst_muted_o", g + 1, {23'b0, muted_o[g]}, 24'h1);
        end
    endtask

    task automatic check_all();
        hist_t       e;
        logic [23:0] evd;
        for (int g = 0; g < 4; g++) begin
            e   = hist[g];
            evd = !e.de ? 24'h0 : (e.tag ? MUTE_C : e.vd);
            check("VSYNC_o", g + 1, {23'b0, vs_o[g]}, {23'b0, e.vs});
            check("HSYNC_o", g + 1, {23'b0, hs_o[g]}, {23'b0, e.hs});
            check("DE_o",    g + 1, {23'b0, de_o[g]}, {23'b0, e.de});
            check("VD_o",    g + 1, vd_o[g],          evd);
            check("muted_o", g + 1, {23'b0, muted_o[g]}, {23'b0, hist[1].tag});
        end
    endtask

    // Drive one pixel, record it with its expected mute tag, clock, then check.
    task automatic pix(input logic vs, input logic hs, input logic de, input logic mreq, input logic tag);
        VSYNC_i    = vs;
        HSYNC_i    = hs;
        DE_i       = de;
        mute_req_i = mreq;
        VD_i       = ramp;
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = '{vs: vs ^ vs_pol_i, hs: hs ^ hs_pol_i, de: de, tag: tag, vd: ramp};
        ramp = ramp + 24'h1;
        @(posedge VCLK_Tx);
        #1;
        check_all();
    endtask

    // 4 lines x 12 pixels; VSYNC_i high for line 0 (rise at pixel 0),
    // DE on pixels 0..7, HSYNC_i on pixels 10..11. pulse_at >= 0 raises
    // mute_req_i for that single pixel; it and all later pixels are muted.
    task automatic frame(input logic tag0, input int pulse_at);
        int   idx;
        logic t;
        for (int ln = 0; ln < 4; ln++) begin
            for (int px = 0; px < 12; px++) begin
                idx = ln * 12 + px;
                t   = (pulse_at >= 0 && idx >= pulse_at) ? 1'b1 : tag0;
                pix(ln == 0, px >= 10, px < 8, idx == pulse_at, t);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) hist[i] = '{vs: 1'b0, hs: 1'b0, de: 1'b0, tag: 1'b1, vd: 24'h0};

        // asynchronous reset, checked before any clock edge
        #2 nVRST_Tx = 1'b0;
        #1 check_reset();
        repeat (2) @(posedge VCLK_Tx);
        #1 check_reset();
        nVRST_Tx = 1'b1;

        // start-up: MUTE -> WAIT, two VSYNC rises, unmute on the second
        for (int i = 0; i < 4; i++) pix(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(1'b1, -1);
        frame(1'b0, -1);
        frame(1'b0, -1);

        // single-cycle mute pulse during active video while running
        frame(1'b0, 19);
        frame(1'b1, -1);

        // mute request coincident with a VSYNC rise while waiting
        frame(1'b1, 0);
        frame(1'b1, -1);
        frame(1'b0, -1);

        // VSYNC polarity inverted, then restored mid-line
        vs_pol_i = 1'b1;
        frame(1'b0, -1);
        for (int px = 0; px < 12; px++) begin
            if (px == 5) vs_pol_i = 1'b0;
            pix(1'b0, px >= 10, px < 8, 1'b0, 1'b0);
        end

        // HSYNC polarity inverted for one frame
        hs_pol_i = 1'b1;
        frame(1'b0, -1);
        hs_pol_i = 1'b0;
        for (int i = 0; i < 6; i++) pix(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset in the middle of active video clears outputs without a clock
        for (int i = 0; i < 5; i++) pix(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nVRST_Tx = 1'b0;
        #1 check_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
